// File: rtl/btn_event_gen_pkg.sv
// Shared definitions for the push-button event generator: channel FSM states,
// default timing constants, board button indices and a counter-width helper.
package btn_event_gen_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      PRESS_DB   = 3'd1,
      HELD       = 3'd2,
      LONG       = 3'd3,
      RELEASE_DB = 3'd4
   } btnState_e;

   // Defaults assume a 100 MHz clock: 20 ms debounce, 3 s long press, 0.5 s repeat.
   localparam int DEF_NUM_BTN         = 8;
   localparam int DEF_DEBOUNCE_CYCLES = 2_000_000;
   localparam int DEF_LONG_CYCLES     = 300_000_000;
   localparam int DEF_REPEAT_CYCLES   = 50_000_000;

   // Bit positions of the hood buttons on btn_raw and on every output vector.
   localparam int BTN_POWER = 0;
   localparam int BTN_MENU  = 1;
   localparam int BTN_MODE1 = 2;
   localparam int BTN_MODE2 = 3;
   localparam int BTN_MODE3 = 4;
   localparam int BTN_CLEAN = 5;
   localparam int BTN_LEFT  = 6;
   localparam int BTN_RIGHT = 7;

   // One spare bit above what the largest count needs, so terminal counts never wrap.
   function automatic int cntWidth(input int maxVal);
      return $clog2(maxVal) + 1;
   endfunction

endpackage

// File: rtl/btn_event_gen_channel.sv
// One button channel: 2-flop synchroniser, debounce/hold FSM and its counters.
// Produces the debounced level plus press, short-release and long-press pulses.
// Optional auto-repeat of long_o while held is compiled in with BTN_REPEAT_EN.
module btn_event_gen_channel
   import btn_event_gen_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
   parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic btnRaw_i,
   output logic held_o,
   output logic press_o,
   output logic short_o,
   output logic long_o
);

   localparam int DB_W   = cntWidth(DEBOUNCE_CYCLES);
   localparam int HOLD_W = cntWidth(LONG_CYCLES);

   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

   // Reject timing combinations the FSM cannot honour at elaboration time.
   if ((DEBOUNCE_CYCLES < 2) || (LONG_CYCLES <= DEBOUNCE_CYCLES) || (REPEAT_CYCLES < 1)) begin : gBadParams
      $error("btn_event_gen_channel: illegal timing parameters");
   end

   logic              syncMeta_q;
   logic              sync_q;
   btnState_e         state_q;
   logic [DB_W-1:0]   dbCnt_q;
   logic [DB_W-1:0]   dbCnt_d;
   logic [HOLD_W-1:0] holdCnt_q;
   logic [HOLD_W-1:0] holdCnt_d;
   logic              fired_q;
   logic              held_q;
   logic              press_q;
   logic              short_q;
   logic              long_q;

`ifdef BTN_REPEAT_EN
   localparam int REP_W = cntWidth(REPEAT_CYCLES);
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

   logic [REP_W-1:0] repCnt_q;
`endif

   // Bring the asynchronous pin into the clock domain before anything looks at it.
   always_ff @(posedge clk) begin
      if (reset) begin
         syncMeta_q <= 1'b0;
         sync_q     <= 1'b0;
      end else begin
         syncMeta_q <= btnRaw_i;
         sync_q     <= syncMeta_q;
      end
   end

   // Counter increments; the hold count parks at its terminal value so a very long hold cannot wrap.
   always_comb begin
      dbCnt_d   = dbCnt_q + DB_W'(1);
      holdCnt_d = holdCnt_q;
      if (holdCnt_q != HOLD_LAST) begin
         holdCnt_d = holdCnt_q + HOLD_W'(1);
      end
   end

   // Channel FSM: debounce both edges, time the hold, emit registered single-cycle pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         dbCnt_q   <= '0;
         holdCnt_q <= '0;
         fired_q   <= 1'b0;
         held_q    <= 1'b0;
         press_q   <= 1'b0;
         short_q   <= 1'b0;
         long_q    <= 1'b0;
`ifdef BTN_REPEAT_EN
         repCnt_q  <= '0;
`endif
      end else begin
         press_q <= 1'b0;
         short_q <= 1'b0;
         long_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (sync_q) begin
                  state_q <= PRESS_DB;
                  dbCnt_q <= '0;
               end
            end
            PRESS_DB: begin
               if (!sync_q) begin
                  state_q <= IDLE;
               end else if (dbCnt_q == DB_LAST) begin
                  state_q   <= HELD;
                  held_q    <= 1'b1;
                  press_q   <= 1'b1;
                  holdCnt_q <= '0;
                  fired_q   <= 1'b0;
               end else begin
                  dbCnt_q <= dbCnt_d;
               end
            end
            HELD: begin
               holdCnt_q <= holdCnt_d;
               if (!sync_q) begin
                  state_q <= RELEASE_DB;
                  dbCnt_q <= '0;
                  fired_q <= 1'b0;
               end else if (holdCnt_q == HOLD_LAST) begin
                  state_q  <= LONG;
                  long_q   <= 1'b1;
                  fired_q  <= 1'b1;
`ifdef BTN_REPEAT_EN
                  repCnt_q <= '0;
`endif
               end
            end
            LONG: begin
               if (!sync_q) begin
                  state_q <= RELEASE_DB;
                  dbCnt_q <= '0;
`ifdef BTN_REPEAT_EN
               end else if (repCnt_q == REP_LAST) begin
                  long_q   <= 1'b1;
                  repCnt_q <= '0;
               end else begin
                  repCnt_q <= repCnt_q + REP_W'(1);
`endif
               end
            end
            RELEASE_DB: begin
               holdCnt_q <= holdCnt_d;
               if (sync_q) begin
                  state_q <= fired_q ? LONG : HELD;
               end else if (dbCnt_q == DB_LAST) begin
                  state_q <= IDLE;
                  held_q  <= 1'b0;
                  short_q <= !fired_q;
               end else begin
                  dbCnt_q <= dbCnt_d;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign held_o  = held_q;
   assign press_o = press_q;
   assign short_o = short_q;
   assign long_o  = long_q;

endmodule

// File: rtl/btn_event_gen.sv
// Push-button event generator: turns raw board buttons into clean per-button
// events (press, short release, long press) plus a debounced held level.
// Each button gets its own independent btn_event_gen_channel instance.
// Define BTN_REPEAT_EN to repeat long_pulse every REPEAT_CYCLES while held.
module btn_event_gen
   import btn_event_gen_pkg::*;
#(
   parameter int NUM_BTN         = DEF_NUM_BTN,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
   parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_BTN-1:0] btn_raw,
   output logic [NUM_BTN-1:0] btn_held,
   output logic [NUM_BTN-1:0] press_pulse,
   output logic [NUM_BTN-1:0] short_pulse,
   output logic [NUM_BTN-1:0] long_pulse
);

   for (genvar i = 0; i < NUM_BTN; i++) begin : gChan
      btn_event_gen_channel #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .LONG_CYCLES    (LONG_CYCLES),
         .REPEAT_CYCLES  (REPEAT_CYCLES)
      ) uChannel (
         .clk     (clk),
         .reset   (reset),
         .btnRaw_i(btn_raw[i]),
         .held_o  (btn_held[i]),
         .press_o (press_pulse[i]),
         .short_o (short_pulse[i]),
         .long_o  (long_pulse[i])
      );
   end

endmodule
